// File: rtl/hash_gen_pkg.sv
// Shared definitions for the multi-channel rolling hash generator:
// command bit positions, rotate helper and the digest record layout.
package hash_gen_pkg;

    localparam int CMD_EMIT_BIT = 8;
    localparam int CMD_SEED_BIT = 9;
    localparam logic [7:0] DEF_CMD_CODE = 8'h00;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_CH_W   = 2;
    localparam int DEF_CNT_W  = 16;

    // Widest hash the rotate helper supports; narrower words are zero-extended.
    localparam int ROTL_MAX_W = 512;

    // Digest record at the default widths; the top builds the same layout from its parameters.
    typedef struct packed {
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_DATA_W-1:0] hash;
        logic [DEF_CNT_W-1:0]  cnt;
    } digest_t;

    function automatic logic [ROTL_MAX_W-1:0] rotl(input logic [ROTL_MAX_W-1:0] v,
                                                  input int w,
                                                  input int r);
        logic [ROTL_MAX_W-1:0] ones;
        logic [ROTL_MAX_W-1:0] mask;
        ones = '1;
        mask = ones >> (ROTL_MAX_W - w);
        return ((v << r) | (v >> (w - r))) & mask;
    endfunction

endpackage

// File: rtl/hash_gen_mc_fifo.sv
// Generic synchronous FIFO with full/empty flags, used as the digest output queue.
module hash_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q];

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/hash_gen_mc.sv
// Multi-channel XOR-rotate hash generator: command words seed/absorb/emit per
// channel, and emitted digests leave through a valid/ready output FIFO.
module hash_gen_mc
    import hash_gen_pkg::*;
#(
    parameter int         DATA_W     = 128,
    parameter int         CH_N       = 4,
    parameter int         ROT        = 1,
    parameter logic [7:0] CMD_CODE   = DEF_CMD_CODE,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 16,
    localparam int        CH_W       = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CH_W-1:0]   ch_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              valid_o,
    input  logic              ready_i
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] hash;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    logic [DATA_W-1:0] hash_q [CH_N];
    logic [DATA_W-1:0] hash_d [CH_N];
    logic [CNT_W-1:0]  cnt_q  [CH_N];
    logic [CNT_W-1:0]  cnt_d  [CH_N];

    logic              fifoFull, fifoEmpty;
    logic              accept, isCmd, chValid, cmdFire, isSeed, pushDigest;
    logic [CH_W-1:0]   chIdx;
    logic [DATA_W-1:0] selHash, newHash;
    logic [CNT_W-1:0]  selCnt, newCnt;
    entry_t            pushEntry, headEntry;

    assign ready_o = !fifoFull;
    assign accept  = valid_i && ready_o;
    assign isCmd   = (data_i[7:0] == CMD_CODE);
    assign chValid = (32'(ch_i) < CH_N);
    assign cmdFire = accept && isCmd && chValid;
    assign isSeed  = data_i[CMD_SEED_BIT];
    // Out-of-range channels never fire, so steering them to 0 keeps the index legal.
    assign chIdx   = chValid ? ch_i : '0;

    always_comb begin
        hash_d  = hash_q;
        cnt_d   = cnt_q;
        selHash = hash_q[chIdx];
        selCnt  = cnt_q[chIdx];
        if (isSeed) begin
            newHash = data_i;
            newCnt  = CNT_W'(1);
        end else begin
            newHash = data_i ^ DATA_W'(rotl(ROTL_MAX_W'(selHash), DATA_W, ROT));
            newCnt  = (&selCnt) ? selCnt : selCnt + CNT_W'(1);
        end
        if (cmdFire) begin
            hash_d[chIdx] = newHash;
            cnt_d[chIdx]  = newCnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_N; c++) begin
                hash_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            hash_q <= hash_d;
            cnt_q  <= cnt_d;
        end
    end

    // The digest carries the post-update hash and count, so the emitting word is included.
    always_comb begin
        pushDigest     = cmdFire && data_i[CMD_EMIT_BIT];
        pushEntry.ch   = chIdx;
        pushEntry.hash = newHash;
        pushEntry.cnt  = newCnt;
    end

    hash_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushDigest),
        .wdata_i (pushEntry),
        .pop_i   (valid_o && ready_i),
        .rdata_o (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign valid_o = !fifoEmpty;
    assign data_o  = headEntry.hash;
    assign ch_o    = headEntry.ch;
    assign cnt_o   = headEntry.cnt;

endmodule

// File: tb/tb_hash_gen_mc.sv
// Self-checking bench for hash_gen_mc: directed vector table, backpressure and
// reset sequences, randomized traffic against a scoreboard, and a narrow saturating instance.
module tb_hash_gen_mc;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data_i = '0;
    logic [1:0]   ch_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [127:0] data_o;
    logic [1:0]   ch_o;
    logic [15:0]  cnt_o;
    logic         valid_o;
    logic         ready_i = 1'b1;

    logic [15:0]  d2Data = '0;
    logic [1:0]   d2Ch = '0;
    logic         d2Valid = 1'b0;
    logic         d2ReadyO;
    logic [15:0]  d2Out;
    logic [1:0]   d2ChO;
    logic [3:0]   d2Cnt;
    logic         d2ValidO;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hash_gen_mc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .ch_i    (ch_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .ch_o    (ch_o),
        .cnt_o   (cnt_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    hash_gen_mc #(
        .DATA_W (16),
        .CH_N   (3),
        .CNT_W  (4)
    ) dutNarrow (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (d2Data),
        .ch_i    (d2Ch),
        .valid_i (d2Valid),
        .ready_o (d2ReadyO),
        .data_o  (d2Out),
        .ch_o    (d2ChO),
        .cnt_o   (d2Cnt),
        .valid_o (d2ValidO),
        .ready_i (1'b1)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: one rolling hash per channel, digests queued in emit order.
    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   ch;
        logic [15:0]  cnt;
    } dig_t;

    logic [127:0] mHash [4];
    int           mCnt  [4];
    dig_t         expQ[$];
    dig_t         popE, pushE;
    int           mc;

    function automatic logic [127:0] rotlRef(input logic [127:0] h);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) begin
            r[(i + 1) % 128] = h[i];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            for (int i = 0; i < 4; i++) begin
                mHash[i] = '0;
                mCnt[i]  = 0;
            end
        end else begin
            if (valid_o && ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput("sb_unexpected_digest", 128'd1, 128'd0);
                end else begin
                    popE = expQ.pop_front();
                    checkOutput("sb_data", data_o, popE.data);
                    checkOutput("sb_ch", 128'(ch_o), 128'(popE.ch));
                    checkOutput("sb_cnt", 128'(cnt_o), 128'(popE.cnt));
                end
            end
            if (valid_i && ready_o && data_i[7:0] == 8'h00) begin
                mc = int'(ch_i);
                if (data_i[9]) begin
                    mHash[mc] = data_i;
                    mCnt[mc]  = 1;
                end else begin
                    mHash[mc] = data_i ^ rotlRef(mHash[mc]);
                    mCnt[mc]  = (mCnt[mc] >= 65535) ? 65535 : mCnt[mc] + 1;
                end
                if (data_i[8]) begin
                    pushE.data = mHash[mc];
                    pushE.ch   = ch_i;
                    pushE.cnt  = 16'(mCnt[mc]);
                    expQ.push_back(pushE);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic applyStimulus(input logic [127:0] data, input logic [1:0] ch);
        int waited = 0;
        data_i  = data;
        ch_i    = ch;
        valid_i = 1'b1;
        while (!ready_o && waited < 40) begin
            @(negedge clk);
            waited++;
            if (waited > 2) ready_i = 1'b1;
        end
        if (!ready_o) checkOutput("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic applyStimulusNarrow(input logic [15:0] data, input logic [1:0] ch);
        d2Data  = data;
        d2Ch    = ch;
        d2Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d2Valid = 1'b0;
    endtask

    task automatic drainQueue(input string name);
        int n = 0;
        ready_i = 1'b1;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_queue_empty"}, 128'(expQ.size()), 128'd0);
        @(negedge clk);
        checkOutput({name, "_valid_low"}, 128'(valid_o), 128'd0);
    endtask

    typedef struct {
        logic [127:0] data;
        logic [1:0]   ch;
        logic         expValid;
        logic [127:0] expData;
        logic [15:0]  expCnt;
    } vec_t;

    vec_t         vecs[12];
    logic [127:0] bpW[5];
    logic [127:0] rnd;

    initial begin
        vecs[0]  = '{128'h300, 2'd0, 1'b1, 128'h300, 16'd1};
        vecs[1]  = '{128'h200, 2'd1, 1'b0, 128'h0, 16'd0};
        vecs[2]  = '{128'h35A, 2'd1, 1'b0, 128'h0, 16'd0};
        vecs[3]  = '{128'h100, 2'd1, 1'b1, 128'h500, 16'd2};
        vecs[4]  = '{128'h100, 2'd3, 1'b1, 128'h100, 16'd1};
        vecs[5]  = '{128'hABCD0200, 2'd2, 1'b0, 128'h0, 16'd0};
        vecs[6]  = '{128'h1_0000_0100, 2'd0, 1'b1, 128'h1_0000_0700, 16'd2};
        vecs[7]  = '{128'h100, 2'd2, 1'b1, 128'h1_579A_0500, 16'd2};
        vecs[8]  = '{128'h101, 2'd0, 1'b0, 128'h0, 16'd0};
        vecs[9]  = '{128'h100, 2'd0, 1'b1, 128'h2_0000_0F00, 16'd3};
        vecs[10] = '{128'h8000_0000_0000_0000_0000_0000_0000_0200, 2'd3, 1'b0, 128'h0, 16'd0};
        vecs[11] = '{128'h100, 2'd3, 1'b1, 128'h501, 16'd2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 128'(ready_o), 128'd1);
        checkOutput("reset_valid", 128'(valid_o), 128'd0);
        checkOutput("reset_data", data_o, 128'd0);
        checkOutput("reset_ch", 128'(ch_o), 128'd0);
        checkOutput("reset_cnt", 128'(cnt_o), 128'd0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].data, vecs[i].ch);
            checkOutput($sformatf("vec%0d_valid", i), 128'(valid_o), 128'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_data", i), data_o, vecs[i].expData);
                checkOutput($sformatf("vec%0d_ch", i), 128'(ch_o), 128'(vecs[i].ch));
                checkOutput($sformatf("vec%0d_cnt", i), 128'(cnt_o), 128'(vecs[i].expCnt));
            end
        end
        drainQueue("table");

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) begin
            bpW[i] = 128'h300 | (128'(i + 1) << 16);
        end
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bpW[i], 2'd1);
        end
        checkOutput("bp_ready_low", 128'(ready_o), 128'd0);
        checkOutput("bp_head", data_o, bpW[0]);
        data_i  = bpW[4];
        ch_i    = 2'd2;
        valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_stable_data", data_o, bpW[0]);
            checkOutput("bp_stable_valid", 128'(valid_o), 128'd1);
            checkOutput("bp_stall_ready", 128'(ready_o), 128'd0);
        end
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready_rise", 128'(ready_o), 128'd1);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        checkOutput("bp_order_head", data_o, bpW[2]);
        drainQueue("bp");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            if (($urandom % 8) < 6) rnd[7:0] = 8'h00;
            ready_i = (($urandom % 4) != 0);
            applyStimulus(rnd, 2'($urandom % 4));
            if (($urandom % 5) == 0) @(negedge clk);
        end
        drainQueue("rand");

        $display("[TB] reset mid-stream");
        ready_i = 1'b0;
        applyStimulus(128'hAA_0300, 2'd0);
        applyStimulus(128'hBB_0300, 2'd0);
        checkOutput("rst_pre_valid", 128'(valid_o), 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", 128'(valid_o), 128'd0);
        checkOutput("rst_async_data", data_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        applyStimulus(128'h1234_0100, 2'd0);
        checkOutput("rst_after_valid", 128'(valid_o), 128'd1);
        checkOutput("rst_after_data", data_o, 128'h1234_0100);
        checkOutput("rst_after_cnt", 128'(cnt_o), 128'd1);
        drainQueue("rst");

        $display("[TB] saturation and invalid channel");
        applyStimulusNarrow(16'h0200, 2'd0);
        for (int i = 0; i < 19; i++) begin
            applyStimulusNarrow(16'h0000, 2'd0);
        end
        applyStimulusNarrow(16'h0100, 2'd0);
        checkOutput("sat_valid", 128'(d2ValidO), 128'd1);
        checkOutput("sat_data", 128'(d2Out), 128'h2100);
        checkOutput("sat_cnt", 128'(d2Cnt), 128'd15);
        applyStimulusNarrow(16'h0300, 2'd3);
        checkOutput("inv_ch_no_emit", 128'(d2ValidO), 128'd0);
        @(negedge clk);
        checkOutput("inv_ch_still_idle", 128'(d2ValidO), 128'd0);
        applyStimulusNarrow(16'h0100, 2'd0);
        checkOutput("inv_ch0_data", 128'(d2Out), 128'h4300);
        checkOutput("inv_ch0_cnt", 128'(d2Cnt), 128'd15);
        applyStimulusNarrow(16'h0100, 2'd1);
        checkOutput("inv_ch1_data", 128'(d2Out), 128'h0100);
        checkOutput("inv_ch1_cnt", 128'(d2Cnt), 128'd1);
        checkOutput("inv_ch1_ch", 128'(d2ChO), 128'd1);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
